rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles while other requests are pending; legal range 2..255.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  8  request lines; bit i is requester i.
REQ-005 Port: gnt  output  8  registered grant; one-hot or zero.
REQ-006 Port: gnt_idx  output  3  registered binary index of the granted bit (bit 0 -> 3'b000, bit 7 -> 3'b111).
REQ-007 Port: gnt_valid  output  1  registered; high exactly when gnt is nonzero.

Function
REQ-008 Two states: IDLE (no grant) and BUSY (one grant held).
REQ-009 IDLE, req == 0: remain IDLE; gnt = 0, gnt_valid = 0, gnt_idx holds its last value.
REQ-010 IDLE, req != 0: winner = first set bit searching upward from ptr with wrap 7 -> 0; next cycle gnt = one-hot winner, gnt_idx = winner, gnt_valid = 1, state BUSY.
REQ-011 Latency: a request seen in IDLE at edge N is granted at the outputs after edge N+1, i.e. one cycle.
REQ-012 On every grant, ptr <= (winner + 1) mod 8 (3-bit wrap), and hold_cnt <= 0.
REQ-013 BUSY while req[gnt_idx] = 1: hold the grant and increment hold_cnt, saturating at MAX_HOLD-1.
REQ-014 BUSY, req[gnt_idx] = 0: next cycle gnt = 0, gnt_valid = 0, state IDLE. There is one mandatory dead cycle between grants.
REQ-015 Preemption applies in BUSY when hold_cnt == MAX_HOLD-1 and any other req bit is set. The grant is released the next cycle exactly as in REQ-014, even if req[gnt_idx] is still high.
REQ-016 If the holder is alone (no other req bits set), the grant is held indefinitely and hold_cnt stays saturated.
REQ-017 Release and preemption in the same cycle are handled as a single release, with no extra cycle.
REQ-018 gnt shall never have more than one bit set; gnt_valid == |gnt at all times.
REQ-019 Requests are sampled only as in REQ-010 and REQ-013 to REQ-015. Changes to non-granted req bits during BUSY do not affect the outputs.

Reset
REQ-020 While reset = 1, asynchronously and regardless of clk: state = IDLE, gnt = 8'h00, gnt_idx = 3'b000, gnt_valid = 0, ptr = 0, hold_cnt = 0.
REQ-021 Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
REQ-022 After reset deasserts, the first arbitration follows REQ-010 with ptr = 0.

Structure
REQ-023 The state encoding constants (IDLE, BUSY) and the requester count (8) and index width (3) belong in a shared package or include file. The same file is used by the 8-to-3 encoder users.
REQ-024 One sub-module, rr_pick8: a combinational rotate-priority picker.
  - inputs: req[7:0], ptr[2:0]
  - outputs: one-hot winner[7:0], binary index[2:0], any
  - the index mapping is identical to the existing 8-to-3 one-hot encoding
REQ-025 All outputs are driven directly from flops; there is no combinational path from req to gnt.

Verification
REQ-026 Reset: assert reset mid-grant with gnt = 8'h04 -> gnt = 8'h00, gnt_idx = 0, gnt_valid = 0 before the next clk edge.
REQ-027 Single request: from reset, req = 8'h08 -> one cycle later gnt = 8'h08, gnt_idx = 3'b011. Then req = 0 -> next cycle gnt = 0.
REQ-028 Round robin: from reset, req = 8'hFF held, each holder drops its req for one cycle after its grant. Grants occur in order idx 0,1,2,...,7,0, each separated by one dead cycle.
REQ-029 Wrap: ptr = 6 (after granting idx 5), req = 8'h03 -> gnt = 8'h01 (idx 0), then ptr = 1.
REQ-030 Preemption, MAX_HOLD = 4: req = 8'h81 held steady from reset.
  - idx 0 is granted for exactly 4 cycles, then 1 dead cycle.
  - idx 7 is then granted for 4 cycles, then idx 0 again.
  - A lone holder req = 8'h01 keeps gnt = 8'h01 for 20+ cycles.
REQ-031 A bench assertion checks every cycle:
  - gnt is zero or one-hot
  - gnt_valid == |gnt
  - gnt_idx matches gnt whenever gnt_valid = 1

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Also provides the 8-to-3 one-hot encoder used across the design.
package rr_arbiter_8_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot (or zero) to binary index: bit 0 -> 0, bit 7 -> 7.
    function automatic logic [IDX_W-1:0] enc8(
        input logic [N_REQ-1:0] oh
    );
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Rotate-priority picker: first set request at or above ptr,
// wrapping 7 -> 0. Purely combinational.
module rr_pick8
    import rr_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan upward from ptr; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!any && req[cand]) begin
                winner[cand] = 1'b1;
                any          = 1'b1;
            end
        end
    end

    assign index = enc8(winner);

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a hold limit that forces
// release when other requesters wait; outputs are all registered.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [HOLD_W-1:0] HOLD_MAX =
        HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              holder_req;
    logic              others;
    logic              preempt;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .index  (pick_idx),
        .any    (pick_any)
    );

    assign holder_req = req[idx_q];
    assign others     = |(req & ~gnt_q);
    assign preempt    = (hold_q == HOLD_MAX) && others;

    // Next-state: arbitrate in IDLE, hold or release in BUSY.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (pick_any) begin
                    state_d = BUSY;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    ptr_d   = pick_idx + IDX_W'(1);
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (!holder_req || preempt) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8 with MAX_HOLD = 4.
// Directed vectors push expected outputs; a monitor compares.
module tb_rr_arbiter_8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    typedef struct {
        int         tid;
        int         cyc;
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rr_w;
    logic [7:0] rr_oh;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(
        input string      name,
        input logic [11:0] act,
        input logic [11:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%0b idx=%0d gnt=%02h, want v=%0b idx=%0d gnt=%02h",
                name, act[11], act[10:8], act[7:0],
                exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk($sformatf("t%0d_c%0d", mon_e.tid, mon_e.cyc),
                {gnt_valid, gnt_idx, gnt},
                {mon_e.v, mon_e.i, mon_e.g});
        end
    end

    // Per-cycle invariants on the grant outputs.
    always @(negedge clk) begin
        n_cmp++;
        if ((gnt & (gnt - 8'd1)) != 8'd0) begin
            n_bad++;
            $display("FAIL onehot0: gnt=%02h, want zero or one-hot", gnt);
        end
        n_cmp++;
        if (gnt_valid !== (|gnt)) begin
            n_bad++;
            $display("FAIL valid_or: gnt_valid=%0b, want %0b", gnt_valid, |gnt);
        end
        if (gnt_valid) begin
            n_cmp++;
            if (gnt !== (8'd1 << gnt_idx)) begin
                n_bad++;
                $display("FAIL idx_match: gnt=%02h idx=%0d, want gnt=%02h",
                    gnt, gnt_idx, 8'd1 << gnt_idx);
            end
        end
    end

    task automatic drive(
        input int         tid,
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [2:0] i,
        input logic       v
    );
        @(posedge clk);
        #1;
        req = r;
        sb.push_back('{tid: tid, cyc: cyc + 1, g: g, i: i, v: v});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 8'h00;
        #2;
        chk("reset_state", {gnt_valid, gnt_idx, gnt}, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Single request, then release.
        do_reset();
        drive(1, 8'h08, 8'h08, 3'd3, 1'b1);
        drive(1, 8'h0A, 8'h08, 3'd3, 1'b1);
        drive(1, 8'h00, 8'h00, 3'd3, 1'b0);
        drive(1, 8'h00, 8'h00, 3'd3, 1'b0);

        // Round robin over all eight with dead cycles.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            rr_w  = k % 8;
            rr_oh = 8'd1 << rr_w;
            drive(2, 8'hFF, rr_oh, 3'(rr_w), 1'b1);
            drive(2, 8'hFF & ~rr_oh, 8'h00, 3'(rr_w), 1'b0);
        end

        // Pointer wrap from 6 around to 0, then ptr = 1.
        do_reset();
        drive(3, 8'h20, 8'h20, 3'd5, 1'b1);
        drive(3, 8'h00, 8'h00, 3'd5, 1'b0);
        drive(3, 8'h03, 8'h01, 3'd0, 1'b1);
        drive(3, 8'h00, 8'h00, 3'd0, 1'b0);
        drive(3, 8'h03, 8'h02, 3'd1, 1'b1);
        drive(3, 8'h00, 8'h00, 3'd1, 1'b0);

        // Preemption at MAX_HOLD = 4, then a lone holder.
        do_reset();
        for (int k = 0; k < 4; k++)
            drive(4, 8'h81, 8'h01, 3'd0, 1'b1);
        drive(4, 8'h81, 8'h00, 3'd0, 1'b0);
        for (int k = 0; k < 4; k++)
            drive(4, 8'h81, 8'h80, 3'd7, 1'b1);
        drive(4, 8'h81, 8'h00, 3'd7, 1'b0);
        drive(4, 8'h81, 8'h01, 3'd0, 1'b1);
        for (int k = 0; k < 24; k++)
            drive(4, 8'h01, 8'h01, 3'd0, 1'b1);
        drive(4, 8'h00, 8'h00, 3'd0, 1'b0);

        // Asynchronous reset while idx 2 holds the grant.
        do_reset();
        drive(5, 8'h04, 8'h04, 3'd2, 1'b1);
        drive(5, 8'h04, 8'h04, 3'd2, 1'b1);
        drain();
        #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_grant", {gnt_valid, gnt_idx, gnt}, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 8'h00;
        drive(5, 8'h04, 8'h04, 3'd2, 1'b1);
        drive(5, 8'h00, 8'h00, 3'd2, 1'b0);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
